// File: rtl/onehot_demux_stage_if.sv
// rtl/onehot_demux_stage_if.sv - valid/ready stream bundle for the one-hot demux stage
interface onehot_demux_stage_if #(
    parameter int OUTPUTS = 4,
    parameter int WIDTH   = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [OUTPUTS-1:0] in_sel;
    logic [OUTPUTS-1:0] out_valid;
    logic [OUTPUTS-1:0] out_ready;
    logic [WIDTH-1:0]   out_data;

    // Producer and consumers of the stage.
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The stage itself.
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/onehot_demux_stage.sv
// rtl/onehot_demux_stage.sv - registered one-hot demultiplexer with illegal-tag drop counter
module onehot_demux_stage #(
    parameter int OUTPUTS = 4,
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    onehot_demux_stage_if.slave bus,
    input  logic             err_clr,
    output logic             err,
    output logic [CNT_W-1:0] drop_cnt
);
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state;
    logic [WIDTH-1:0]   held_data;
    logic [OUTPUTS-1:0] held_sel;

    logic drain;
    logic legal;
    logic accept;
    logic take_beat;
    logic drop_beat;

    // Non-selected ready bits are masked out, so a stray ready cannot drain.
    assign drain     = (state == FULL) && |(held_sel & bus.out_ready);
    assign bus.in_ready = (state == EMPTY) || drain;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign legal     = (bus.in_sel != '0) && ((bus.in_sel & (bus.in_sel - 1'b1)) == '0);
    assign accept    = bus.in_valid && bus.in_ready;
    assign take_beat = accept && legal;
    assign drop_beat = accept && !legal;

    assign bus.out_valid = (state == FULL) ? held_sel : '0;
    assign bus.out_data  = held_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            held_data <= '0;
            held_sel  <= '0;
            err       <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (take_beat) begin
                held_data <= bus.in_data;
                held_sel  <= bus.in_sel;
                state     <= FULL;
            end else if (drain) begin
                state     <= EMPTY;
            end

            // A drop in the same cycle as a clear must still be recorded.
            if (err_clr) begin
                err      <= drop_beat;
                drop_cnt <= drop_beat ? CNT_W'(1) : '0;
            end else if (drop_beat) begin
                err <= 1'b1;
                if (drop_cnt != CNT_MAX) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/onehot_demux_stage.md
Name: onehot_demux_stage

Overview:
- Registered one-hot demultiplexer: the inverse of the one-hot mux.
- Takes a single valid/ready input stream, each beat tagged with a one-hot destination vector, and steers it through one output register stage to exactly one of OUTPUTS valid/ready consumers.
- Sits at fan-out points in the datapath where a one-hot mux recombines the same streams elsewhere.
- Illegal (non-one-hot) tags are dropped and counted.

Parameters:
OUTPUTS, 4, number of destination ports (>=2)
WIDTH, 8, data width in bits (>=1)
CNT_W, 8, width of the saturating drop counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active high
in_valid  input  1  input beat present
in_ready  output  1  stage can take input beat this cycle
in_data  input  WIDTH  input payload
in_sel  input  OUTPUTS  one-hot destination tag for input beat
out_valid  output  OUTPUTS  per-destination valid; at most one bit set
out_ready  input  OUTPUTS  per-destination ready
out_data  output  WIDTH  payload shared by all destinations, qualified by out_valid
err  output  1  sticky: an illegal in_sel was seen
err_clr  input  1  clears err and drop_cnt
drop_cnt  output  CNT_W  number of dropped beats, saturating at all-ones

Behaviour:
- Reset (rst=1 at clock edge): out_valid=0, out_data=0, err=0, drop_cnt=0, state EMPTY. rst overrides all other inputs, including a pending held beat, which is discarded.
- State machine:
  - EMPTY: no beat held.
  - FULL: beat held in held_data/held_sel.
  - out_valid = held_sel when FULL, else 0.
  - out_data = held_data; it is 0 after reset and retains its last value when EMPTY.
- drain = FULL & |(held_sel & out_ready). out_ready bits of non-selected destinations are ignored.
- in_ready = EMPTY | drain. This is combinational from out_ready; no combinational path from in_valid to in_ready.
- legal = in_sel has exactly one bit set (popcount==1).
- Accept = in_valid & in_ready.
- Accept with legal tag: load held_data=in_data and held_sel=in_sel; next state FULL.
- Accept with illegal tag (zero bits or multiple bits set):
  - Beat consumed and discarded; held register not loaded.
  - err set to 1; drop_cnt increments by 1, saturating at 2^CNT_W-1 (no wrap).
  - Next state: EMPTY if draining or already EMPTY.
- Drain without a legal accept: next state EMPTY.
- Drain and legal accept in the same cycle: the new beat replaces the old one and state stays FULL. This gives full throughput of 1 beat/cycle.
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N (cycle N+1).
- Stability: while FULL and not drained, held_sel and held_data are unchanged and in_ready=0.
- err_clr=1: err<=0, drop_cnt<=0. If err_clr coincides with an illegal accept, the error wins: err=1, drop_cnt=1.
- in_sel/in_data are don't-care when in_valid=0.
- No combinational path from in_data/in_sel to any output.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, err=0, drop_cnt=0, no beat accepted. Then drive in_valid=1, in_sel=4'b0100, in_data=8'hA5, out_ready=4'b1111 -> next cycle out_valid=4'b0100, out_data=8'hA5.
- Backpressure: load beat in_sel=4'b0010, data 8'h11; set out_ready=4'b1101 for 3 cycles -> out_valid=4'b0010 held and data stable, in_ready=0. Then set out_ready[1]=1 -> drain, in_ready=1 in that cycle.
- Streaming: 8 consecutive beats (data 0..7) with in_sel rotating 0001→0010→0100→1000 and out_ready=all ones -> one beat per cycle, each appearing one cycle after acceptance on the matching out_valid bit, in order, none lost.
- Illegal tags: send in_sel=4'b0000 then 4'b0110 -> both accepted (in_ready=1), out_valid stays 0, err=1, drop_cnt=2. Then send a legal beat -> delivered normally, and err stays 1.
- Saturation/clear: with CNT_W=2, send 5 illegal beats -> drop_cnt=3 (not 1). Then assert err_clr together with a 6th illegal beat -> err=1, drop_cnt=1. Then err_clr alone -> err=0, drop_cnt=0.
- Reset mid-operation: FULL with out_ready=0, assert rst for 1 cycle -> out_valid=0, in_ready=1 next cycle, and the held beat is never delivered.
